// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: bundles the hazard controller's stall/exception inputs and pipeline control outputs.
// Latency: none, wires only.
// Backpressure: the stall requests are the backpressure; master = pipeline, slave = controller.
interface pipe_hazard_ctrl_if;
  // pipeline -> controller
  logic        stall_if_req;
  logic        stall_id_req;
  logic        stall_ex_req;
  logic        stall_mem_req;
  logic [31:0] except_type;
  logic [31:0] cp0_epc;
  // controller -> pipeline
  logic        en_pc;
  logic        en_if_id;
  logic        en_id_ex;
  logic        en_ex_mem;
  logic        en_mem_wb;
  logic [3:0]  bubble;
  logic        flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        watchdog_err;

  modport master (
    output stall_if_req, stall_id_req, stall_ex_req, stall_mem_req, except_type, cp0_epc,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, bubble, flush,
           new_pc_valid, new_pc, watchdog_err
  );

  modport slave (
    input  stall_if_req, stall_id_req, stall_ex_req, stall_mem_req, except_type, cp0_epc,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, bubble, flush,
           new_pc_valid, new_pc, watchdog_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage pipeline; RUN -> FLUSH -> REDIRECT on exception.
// Latency: stall enables/bubbles are combinational (0 cycles); exception redirect >= 2 cycles.
// Backpressure: oldest stalling stage freezes itself and everything younger; FLUSH waits for idle fetch.
// Optional: define PIPE_STALL_WATCHDOG_EN for the sticky stall-timeout flag (WDT_LIMIT cycles).
module pipe_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000E
`ifdef PIPE_STALL_WATCHDOG_EN
  ,
  parameter int unsigned WDT_LIMIT  = 1024
`endif
) (
  input  logic               clk,
  input  logic               rst,  // asynchronous, active-low
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        exc;
  logic [4:0]  en;   // bit i = register i (PC=0 .. MEM/WB=4)
  logic [3:0]  bub;  // bit k = NOP into register k+1

  assign exc = (hz.except_type != 32'd0);

  // Next state and redirect-target capture; the target is latched only on the RUN exception cycle.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc) begin
          state_d  = ST_FLUSH;
          new_pc_d = (hz.except_type == ERET_CODE) ? hz.cp0_epc : EXC_VECTOR;
        end
      end
      // Never redirect while a fetch is still in flight.
      ST_FLUSH:    if (!hz.stall_if_req) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // State and target registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Enable/bubble decode: oldest stalling stage k holds registers 0..k and bubbles register k+1.
  // An exception looks like a MEM stall so the excepting instruction leaves as a NOP in MEM/WB.
  always_comb begin
    en  = 5'b00000;
    bub = 4'b0000;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (exc || hz.stall_mem_req) begin
            en  = 5'b10000;
            bub = 4'b1000;
          end else if (hz.stall_ex_req) begin
            en  = 5'b11000;
            bub = 4'b0100;
          end else if (hz.stall_id_req) begin
            en  = 5'b11100;
            bub = 4'b0010;
          end else if (hz.stall_if_req) begin
            en  = 5'b11110;
            bub = 4'b0001;
          end else begin
            en  = 5'b11111;
          end
        end
        ST_REDIRECT: en = 5'b00001;
        default:     en = 5'b00000;
      endcase
    end
  end

  assign hz.en_pc        = en[0];
  assign hz.en_if_id     = en[1];
  assign hz.en_id_ex     = en[2];
  assign hz.en_ex_mem    = en[3];
  assign hz.en_mem_wb    = en[4];
  assign hz.bubble       = bub;
  assign hz.flush        = (state_q == ST_FLUSH);
  assign hz.new_pc_valid = (state_q == ST_REDIRECT);
  assign hz.new_pc       = new_pc_q;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam logic [15:0] WDT_LIM16 = 16'(WDT_LIMIT);

  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_err_q, wdt_err_d;
  logic        any_stall;

  assign any_stall = hz.stall_if_req | hz.stall_id_req | hz.stall_ex_req | hz.stall_mem_req;

  // Consecutive-stall counter: clears on a clean cycle or outside RUN, saturates at the limit.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_err_d = wdt_err_q;
    if ((state_q != ST_RUN) || !any_stall) begin
      wdt_cnt_d = 16'd0;
    end else if (wdt_cnt_q < WDT_LIM16) begin
      wdt_cnt_d = wdt_cnt_q + 16'd1;
    end
    if (wdt_cnt_d == WDT_LIM16) wdt_err_d = 1'b1;
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_q <= 16'd0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign hz.watchdog_err = wdt_err_q;
`else
  assign hz.watchdog_err = 1'b0;
`endif

endmodule
